// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with 3-sample majority vote and show-ahead receive FIFO
module uart_rx_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int KW    = 19
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    input  logic [KW-1:0]          k,
    input  logic [3:0]             nbits,
    input  logic                   pen,
    input  logic                   even,
    input  logic                   rd,
    input  logic                   clr_ovf,
    output logic [DW-1:0]          data,
    output logic                   perr,
    output logic                   ferr,
    output logic                   brk,
    output logic                   rxrdy,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DW + 3;
    localparam logic [3:0]    DW4      = 4'(DW);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [KW-1:0] ONE      = KW'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t         state, state_nxt;
    logic           rx_s1, rx_s2, rx_h;
    logic           fall;
    logic [3:0]     nb_clamped;
    logic [KW-1:0]  k_r, btc, h, h_m1, h_p1;
    logic [3:0]     nb_r, bit_cnt;
    logic           pen_r, even_r;
    logic           samp_a, samp_b, vote, vote_now, last_bit;
    logic [DW-1:0]  shreg, data_al;
    logic           any_one, par_err;
    logic           wr_en;
    logic [EW-1:0]  entry_w, head;

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    cnt_r;
    logic           full, empty, pop, push, ovf_set;

    // Flops reset high so the line idling high never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_h  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_h  <= rx_s2;
        end
    end

    assign fall = rx_h & ~rx_s2;

    always_comb begin
        nb_clamped = nbits;
        if (nbits < 4'd5)
            nb_clamped = 4'd5;
        else if (nbits > DW4)
            nb_clamped = DW4;
    end

    assign h     = k_r >> 1;
    assign h_m1  = h - ONE;
    assign h_p1  = h + ONE;
    assign vote  = (samp_a & samp_b) | (samp_a & rx_s2) | (samp_b & rx_s2);

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        vote_now  = (state != S_IDLE) && (btc == h_p1);
        last_bit  = (bit_cnt == nb_r - 4'd1);
        case (state)
            S_IDLE:   if (fall) state_nxt = S_START;
            S_START:  if (vote_now) state_nxt = vote ? S_IDLE : S_DATA;
            S_DATA:   if (vote_now && last_bit) state_nxt = pen_r ? S_PARITY : S_STOP;
            S_PARITY: if (vote_now) state_nxt = S_STOP;
            S_STOP: begin
                if (vote_now) begin
                    state_nxt = S_IDLE;
                    wr_en     = 1'b1;
                end
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            btc     <= '0;
            k_r     <= '0;
            nb_r    <= 4'd5;
            pen_r   <= 1'b0;
            even_r  <= 1'b0;
            bit_cnt <= '0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
            shreg   <= '0;
            any_one <= 1'b0;
            par_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                btc <= '0;
                if (fall) begin
                    k_r     <= k;
                    nb_r    <= nb_clamped;
                    pen_r   <= pen;
                    even_r  <= even;
                    bit_cnt <= '0;
                    shreg   <= '0;
                    any_one <= 1'b0;
                    par_err <= 1'b0;
                end
            end else begin
                btc <= (btc == k_r - ONE) ? '0 : btc + ONE;
                if (btc == h_m1)
                    samp_a <= rx_s2;
                if (btc == h)
                    samp_b <= rx_s2;
                // Data enters at the MSB so the first bit lands at DW-nb after the last shift
                if (vote_now && state == S_DATA) begin
                    shreg   <= {vote, shreg[DW-1:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                    any_one <= any_one | vote;
                end
                if (vote_now && state == S_PARITY) begin
                    par_err <= vote != (even_r ? ^shreg : ~^shreg);
                    any_one <= any_one | vote;
                end
            end
        end
    end

    assign data_al = shreg >> (DW4 - nb_r);
    assign entry_w = {~any_one & ~vote, ~vote, par_err, data_al};

    assign full    = (cnt_r == FULL_CNT);
    assign empty   = (cnt_r == '0);
    assign pop     = rd & ~empty;
    assign push    = wr_en & (~full | pop);
    assign ovf_set = wr_en & full & ~rd;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= entry_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_r  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
            if (ovf_set)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

    assign head  = mem[rd_ptr];
    assign rxrdy = ~empty;
    assign cnt   = cnt_r;
    assign {brk, ferr, perr, data} = empty ? '0 : head;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised successor to the single-entry UART receive engine. Recovers 5..DW-bit asynchronous serial frames from `rx` with optional parity. Votes each bit over three mid-bit samples and detects false starts and line breaks. Each frame goes into a DEPTH-entry receive FIFO with per-frame error flags, so the host interface can drain bursts without losing characters.

## Interface
- `DW`, 8: maximum data bits per frame; legal range 5..9.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `KW`, 19: width of the bit-time divisor.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx` in 1: serial line, asynchronous, idles high.
- `k` in KW: clocks per bit; must be ≥ 4.
- `nbits` in 4: data bits per frame. Values below 5 act as 5; values above DW act as DW.
- `pen` in 1: parity enable.
- `even` in 1: 1 selects even parity, 0 selects odd.
- `rd` in 1: pop the head entry. Ignored when the FIFO is empty.
- `clr_ovf` in 1: clear `ovf`.
- `data` out DW: head entry data, LSB first as received, zero-extended above nbits. Valid only while `rxrdy` = 1.
- `perr` out 1: head entry parity error.
- `ferr` out 1: head entry framing error (stop bit sampled 0).
- `brk` out 1: head entry is a break.
- `rxrdy` out 1: FIFO not empty.
- `cnt` out $clog2(DEPTH)+1: FIFO occupancy.
- `ovf` out 1: sticky overrun flag.

## Operation
- `rx` passes through a 2-flop synchronizer, plus one history flop for falling-edge detection.
- `k`, `nbits`, `pen` and `even` are latched when a start edge is detected. Changing them mid-frame does not affect the frame in progress.
- Bit-time counter `btc` runs 0..k-1 and wraps to 0. Let h = k>>1.
- Each bit is sampled at btc = h-1, h and h+1. The bit value is the majority of the three samples, decided at btc = h+1.
- States:
  - IDLE: on a synchronized falling edge, go to START with btc = 0.
  - START: at the vote, a result of 1 is a false start; go to IDLE with nothing written. A result of 0 goes to DATA.
  - DATA: collect nbits bits LSB-first. After the last bit, go to PARITY if pen, else STOP.
  - PARITY: vote the parity bit. perr = received parity differs from computed parity (even: XOR of the data bits; odd: its inverse).
  - STOP: at the stop vote, write the entry and go to IDLE.
- Returning to IDLE half a bit early is intentional. A new start is only recognised on a falling edge, so a frame with a low stop bit cannot retrigger until `rx` returns high.
- Entry format: {brk, ferr, perr, data}.
  - ferr = stop vote is 0.
  - brk = all data bits, the parity bit (if pen) and the stop bit voted 0. brk implies ferr.
- FIFO behaviour:
  - Show-ahead: the head entry drives the outputs directly from storage.
  - `rd` with `rxrdy` = 1 pops the head; the next entry appears on the following cycle.
- Overrun: a write while the FIFO is full and `rd` = 0 drops the new frame and sets `ovf`. The FIFO contents are unchanged.
- A write and `rd` in the same cycle while full both take effect; `cnt` stays at DEPTH and `ovf` is not set.
- `ovf` is cleared by `clr_ovf`. A set in the same cycle as a clear wins.
- When empty, `data`, `perr`, `ferr` and `brk` read 0.

## Timing
- Reset values: FSM in IDLE, btc = 0, synchronizer and history flops = 1 (so no false edge after reset), FIFO empty, `cnt` = 0, `rxrdy` = 0, `ovf` = 0, `data`/`perr`/`ferr`/`brk` = 0.
- Asserting `rst_n` low mid-frame discards the partial frame and all FIFO contents.
- Start detection: the falling edge on `rx` reaches the FSM 3 clock edges after the pin changes.
- Per-bit decision: each vote is made at btc = h+1, counted from the start-edge cycle (btc = 0).
- Write timing: the entry is written on the clock edge of the stop vote. `rxrdy` and `cnt` update one cycle later.
- Pin to `rxrdy`: (1+nbits+pen)·k + h + 1 cycles from the start edge reaching the FSM, plus the 3-cycle synchronizer delay.
- `cnt` update rules:
  - Increments on a write.
  - Decrements on a pop.
  - Unchanged when a write and a pop happen in the same cycle.
  - Read and write pointers wrap modulo DEPTH.
- `rd` handshake: `rd` has single-cycle pop semantics. Holding `rd` high pops one entry per cycle until the FIFO is empty, then has no effect.

## Test plan
- **Basic 8N1 frame.** Setup: k = 16, nbits = 8, pen = 0. Stimulus: send 0xA5. Required: `rxrdy` = 1, `data` = 0xA5, perr = ferr = brk = 0, `cnt` = 1. After one `rd` cycle: `rxrdy` = 0.
- **Even parity, 7 bits.** Setup: nbits = 7, pen = 1, even = 1. Stimulus: send 0x41 with a correct parity bit. Required: perr = 0. Stimulus: resend 0x41 with the parity bit inverted. Required: second entry has perr = 1 and data = 0x41.
- **False start and glitch rejection.** Setup: k = 16. Stimulus: pull `rx` low for 4 clocks, then release. Required: no entry written, FSM back in IDLE. Stimulus: during a data bit of an 0x00 frame, a 1-clock high glitch at the sample point. Required: data = 0x00 by majority vote.
- **Framing error and break.** Stimulus: send 0x55 with the stop bit held low. Required: ferr = 1, brk = 0. Stimulus: hold `rx` low for 12 bit times. Required: one entry with data = 0, ferr = 1, brk = 1. No second frame is recognised until `rx` returns high.
- **Overrun, then clear.** Setup: DEPTH = 4. Stimulus: send 0x01..0x05 with no `rd`. Required: `cnt` = 4, `ovf` = 1, entries read back 0x01..0x04. Stimulus: pulse `clr_ovf`. Required: `ovf` = 0. Additional check: a write coinciding with `rd` while full does not set `ovf`.
- **Reset mid-frame.** Stimulus: pulse `rst_n` low during the data bits of a frame while `cnt` = 2. Required: immediately `cnt` = 0, `rxrdy` = 0, `ovf` = 0. A subsequent clean 0x3C frame is received correctly.
